// File: rtl/fib_pkg.sv
// Shared widths, table entry layout, FSM state types and the prefix-mask
// helper for the FIB forwarding table.
package fib_pkg;

   localparam int DEPTH    = 8;
   localparam int PREFIX_W = 64;
   localparam int LEN_W    = 6;
   localparam int DATA_W   = 8;
   localparam int IDX_W    = $clog2(DEPTH);

   typedef struct packed {
      logic                valid;
      logic [PREFIX_W-1:0] prefix;
      logic [LEN_W-1:0]    len;
   } fibEntry_t;

   typedef enum logic [1:0] {
      OUT_IDLE,
      OUT_SCAN,
      OUT_DONE
   } outState_t;

   typedef enum logic [1:0] {
      IN_IDLE,
      IN_OFFER,
      IN_STREAM
   } inState_t;

   // Prefixes are MSB-aligned, so a length of n keeps the top n bits.
   // Length 0 yields an all-zero mask, which makes it match everything.
   function automatic logic [PREFIX_W-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [PREFIX_W-1:0] mask;
      mask = '0;
      if (len != '0) begin
         mask = {PREFIX_W{1'b1}} << (PREFIX_W - int'(len));
      end
      return mask;
   endfunction

endpackage

// File: rtl/fib_lpm_cmp.sv
// Single-entry match test used by the lookup scan: one table entry against
// the latched interest prefix and length.
module fib_lpm_cmp
   import fib_pkg::*;
(
   input  fibEntry_t           entry,
   input  logic [PREFIX_W-1:0] reqPrefix,
   input  logic [LEN_W-1:0]    reqLen,
   output logic                hit,
   output logic [LEN_W-1:0]    len
);

   // An entry matches when it is live, no longer than the request, and its
   // significant bits agree with the request's top bits.
   always_comb begin
      hit = entry.valid
            && (entry.len <= reqLen)
            && (((entry.prefix ^ reqPrefix) & len_mask(entry.len)) == '0);
      len = entry.len;
   end

endmodule

// File: rtl/fib_table.sv
// NDN Forwarding Information Base: a small learned prefix table with a
// sequential longest-prefix-match lookup for the PIT and a learn/offer/stream
// path for incoming data packets. Both paths run concurrently.
module fib_table
   import fib_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [PREFIX_W-1:0] pit_in_prefix,
   input  logic [LEN_W-1:0]    pit_in_len,
   input  logic                fib_out_bit,
   input  logic                start_send_to_pit,
   input  logic                rejected,
   input  logic [LEN_W-1:0]    data_in_len,
   input  logic [PREFIX_W-1:0] data_in_prefix,
   input  logic                data_ready,
   input  logic [DATA_W-1:0]   data_in,
   output logic [LEN_W-1:0]    pit_out_len,
   output logic [PREFIX_W-1:0] pit_out_prefix,
   output logic                prefix_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [PREFIX_W-1:0] longest_matching_prefix,
   output logic [LEN_W-1:0]    longest_matching_prefix_len,
   output logic                clk_out
);

   outState_t           outState, outNext;
   inState_t            inState, inNext;
   fibEntry_t           fibTable [DEPTH];
   logic [IDX_W-1:0]    scanIdx, replacePtr, freeIdx, writeIdx;
   logic [PREFIX_W-1:0] reqPrefix, bestPrefix, dataMasked;
   logic [LEN_W-1:0]    reqLen, bestLen, cmpLen;
   logic                bestFound, cmpHit;
   logic                dataReadyQ, dataRise;
   logic                dupFound, freeFound, learnEn;

   fib_lpm_cmp uCmp (
      .entry     (fibTable[scanIdx]),
      .reqPrefix (reqPrefix),
      .reqLen    (reqLen),
      .hit       (cmpHit),
      .len       (cmpLen)
   );

   // Lookup FSM state register; reset sends it back to idle at any point.
   always_ff @(posedge clk) begin
      if (!rst) outState <= OUT_IDLE;
      else      outState <= outNext;
   end

   // Lookup sequencing: accept a request only while idle, walk every entry
   // once, then spend one cycle publishing the result.
   always_comb begin
      outNext = outState;
      case (outState)
         OUT_IDLE: if (fib_out_bit) outNext = OUT_SCAN;
         OUT_SCAN: if (scanIdx == IDX_W'(DEPTH - 1)) outNext = OUT_DONE;
         OUT_DONE: outNext = OUT_IDLE;
         default:  outNext = OUT_IDLE;
      endcase
   end

   // Lookup datapath: latch the request, keep the best hit seen so far
   // (strictly longer wins, so on a tie the lower index is kept), and
   // register the masked winner with a one-cycle valid strobe. Results
   // persist until the next lookup completes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         scanIdx                     <= '0;
         reqPrefix                   <= '0;
         reqLen                      <= '0;
         bestFound                   <= 1'b0;
         bestPrefix                  <= '0;
         bestLen                     <= '0;
         longest_matching_prefix     <= '0;
         longest_matching_prefix_len <= '0;
         clk_out                     <= 1'b0;
      end else begin
         clk_out <= 1'b0;
         case (outState)
            OUT_IDLE: begin
               if (fib_out_bit) begin
                  reqPrefix  <= pit_in_prefix;
                  reqLen     <= pit_in_len;
                  scanIdx    <= '0;
                  bestFound  <= 1'b0;
                  bestPrefix <= '0;
                  bestLen    <= '0;
               end
            end
            OUT_SCAN: begin
               if (cmpHit && (!bestFound || (cmpLen > bestLen))) begin
                  bestFound  <= 1'b1;
                  bestPrefix <= fibTable[scanIdx].prefix;
                  bestLen    <= cmpLen;
               end
               scanIdx <= scanIdx + 1'b1;
            end
            OUT_DONE: begin
               longest_matching_prefix     <= bestPrefix & len_mask(bestLen);
               longest_matching_prefix_len <= bestLen;
               clk_out                     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Incoming FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) inState <= IN_IDLE;
      else      inState <= inNext;
   end

   // Incoming sequencing: a new packet is offered to the PIT; a vanished
   // packet or a rejection ends the offer (rejection beats acceptance), and
   // an accepted packet streams until data_ready falls.
   always_comb begin
      inNext = inState;
      case (inState)
         IN_IDLE: if (dataRise) inNext = IN_OFFER;
         IN_OFFER: begin
            if (!data_ready || rejected) inNext = IN_IDLE;
            else if (start_send_to_pit)  inNext = IN_STREAM;
         end
         IN_STREAM: if (!data_ready) inNext = IN_IDLE;
         default:   inNext = IN_IDLE;
      endcase
   end

   // Learning decision for the packet currently on the data inputs: skip
   // exact duplicates, otherwise prefer the lowest free slot and fall back
   // to round-robin replacement once the table is full.
   always_comb begin
      dataRise   = data_ready && !dataReadyQ;
      dataMasked = data_in_prefix & len_mask(data_in_len);
      dupFound   = 1'b0;
      freeFound  = 1'b0;
      freeIdx    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (fibTable[i].valid && (fibTable[i].prefix == dataMasked)
             && (fibTable[i].len == data_in_len)) begin
            dupFound = 1'b1;
         end
         if (!fibTable[i].valid) begin
            freeFound = 1'b1;
            freeIdx   = IDX_W'(i);
         end
      end
      writeIdx = freeFound ? freeIdx : replacePtr;
      learnEn  = (inState == IN_IDLE) && dataRise && !dupFound;
   end

   // Table storage: written on the same edge that starts an offer. A write
   // during a lookup scan is only seen by entries the scan has not reached.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) fibTable[i] <= '0;
         replacePtr <= '0;
      end else if (learnEn) begin
         fibTable[writeIdx] <= '{valid: 1'b1, prefix: dataMasked, len: data_in_len};
         if (!freeFound) replacePtr <= replacePtr + 1'b1;
      end
   end

   // Incoming datapath: edge detect on data_ready, the offered prefix, the
   // offer-valid flag and the forwarded payload byte.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dataReadyQ     <= 1'b0;
         pit_out_prefix <= '0;
         pit_out_len    <= '0;
         prefix_ready   <= 1'b0;
         out_data       <= '0;
      end else begin
         dataReadyQ <= data_ready;
         case (inState)
            IN_IDLE: begin
               if (dataRise) begin
                  pit_out_prefix <= data_in_prefix;
                  pit_out_len    <= data_in_len;
                  prefix_ready   <= 1'b1;
               end
            end
            IN_OFFER: begin
               if (!data_ready || rejected) prefix_ready <= 1'b0;
            end
            IN_STREAM: begin
               if (data_ready) begin
                  out_data <= data_in;
               end else begin
                  out_data     <= '0;
                  prefix_ready <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_table.sv
// Self-checking bench for fib_table: directed scenarios plus randomized
// learn/lookup traffic checked against a behavioural table model.
module tb_fib_table;

   localparam int TB_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] pit_in_prefix = '0;
   logic [5:0]  pit_in_len = '0;
   logic        fib_out_bit = 1'b0;
   logic        start_send_to_pit = 1'b0;
   logic        rejected = 1'b0;
   logic [5:0]  data_in_len = '0;
   logic [63:0] data_in_prefix = '0;
   logic        data_ready = 1'b0;
   logic [7:0]  data_in = '0;
   logic [5:0]  pit_out_len;
   logic [63:0] pit_out_prefix;
   logic        prefix_ready;
   logic [7:0]  out_data;
   logic [63:0] longest_matching_prefix;
   logic [5:0]  longest_matching_prefix_len;
   logic        clk_out;

   int compared = 0;
   int mismatched = 0;

   logic        mValid  [TB_DEPTH];
   logic [63:0] mPrefix [TB_DEPTH];
   logic [5:0]  mLen    [TB_DEPTH];
   int          mPtr;

   fib_table dut (
      .clk                         (clk),
      .rst                         (rst),
      .pit_in_prefix               (pit_in_prefix),
      .pit_in_len                  (pit_in_len),
      .fib_out_bit                 (fib_out_bit),
      .start_send_to_pit           (start_send_to_pit),
      .rejected                    (rejected),
      .data_in_len                 (data_in_len),
      .data_in_prefix              (data_in_prefix),
      .data_ready                  (data_ready),
      .data_in                     (data_in),
      .pit_out_len                 (pit_out_len),
      .pit_out_prefix              (pit_out_prefix),
      .prefix_ready                (prefix_ready),
      .out_data                    (out_data),
      .longest_matching_prefix     (longest_matching_prefix),
      .longest_matching_prefix_len (longest_matching_prefix_len),
      .clk_out                     (clk_out)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case some wait below never resolves.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired got timeout want completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] maskOf(input logic [5:0] l);
      logic [63:0] ones;
      ones = '1;
      return ~(ones >> l);
   endfunction

   task automatic modelClear();
      for (int i = 0; i < TB_DEPTH; i++) begin
         mValid[i] = 1'b0; mPrefix[i] = '0; mLen[i] = '0;
      end
      mPtr = 0;
   endtask

   task automatic modelLearn(input logic [63:0] p, input logic [5:0] l);
      logic [63:0] m;
      m = p & maskOf(l);
      for (int i = 0; i < TB_DEPTH; i++)
         if (mValid[i] && mPrefix[i] == m && mLen[i] == l) return;
      for (int i = 0; i < TB_DEPTH; i++)
         if (!mValid[i]) begin
            mValid[i] = 1'b1; mPrefix[i] = m; mLen[i] = l;
            return;
         end
      mPrefix[mPtr] = m; mLen[mPtr] = l;
      mPtr = (mPtr + 1) % TB_DEPTH;
   endtask

   task automatic modelLookup(input logic [63:0] p, input logic [5:0] l,
                              output logic [63:0] rp, output logic [5:0] rl);
      int best;
      best = -1; rp = '0; rl = '0;
      for (int i = 0; i < TB_DEPTH; i++)
         if (mValid[i] && mLen[i] <= l && ((mPrefix[i] ^ p) & maskOf(mLen[i])) == '0
             && int'(mLen[i]) > best) begin
            best = int'(mLen[i]); rp = mPrefix[i]; rl = mLen[i];
         end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b0; fib_out_bit = 1'b0; start_send_to_pit = 1'b0; rejected = 1'b0;
      data_ready = 1'b0; data_in = '0;
      tick(); tick();
      rst = 1'b1;
      modelClear();
   endtask

   task automatic doLookup(input logic [63:0] p, input logic [5:0] l, output int lat,
                           output logic [63:0] rp, output logic [5:0] rl, output logic aft);
      pit_in_prefix = p; pit_in_len = l; fib_out_bit = 1'b1;
      tick();
      fib_out_bit = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (clk_out === 1'b1) begin lat = k; break; end
      end
      rp = longest_matching_prefix; rl = longest_matching_prefix_len;
      tick();
      aft = clk_out;
   endtask

   task automatic learnPrefix(input logic [63:0] p, input logic [5:0] l);
      data_in_prefix = p; data_in_len = l; data_ready = 1'b1;
      tick();
      rejected = 1'b1;
      tick();
      rejected = 1'b0; data_ready = 1'b0;
      tick();
      modelLearn(p, l);
   endtask

   task automatic test_reset();
      int lat; logic [63:0] gp; logic [5:0] gl; logic aft;
      doReset();
      compared++;
      if ({pit_out_len, pit_out_prefix, prefix_ready, out_data, longest_matching_prefix,
           longest_matching_prefix_len, clk_out} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs got %h/%h/%b/%h/%h/%h/%b want all zero", pit_out_len,
                  pit_out_prefix, prefix_ready, out_data, longest_matching_prefix,
                  longest_matching_prefix_len, clk_out);
      end
      doLookup(64'h0000FFFF0000FFFF, 6'd48, lat, gp, gl, aft);
      compared++;
      if (lat !== TB_DEPTH + 1) begin
         mismatched++; $display("[TB] FAIL empty_latency got %0d want %0d", lat, TB_DEPTH + 1);
      end
      compared++;
      if ({gp, gl} !== 70'd0) begin
         mismatched++; $display("[TB] FAIL empty_result got %h/%0d want 0/0", gp, gl);
      end
      compared++;
      if (aft !== 1'b0) begin
         mismatched++; $display("[TB] FAIL strobe_width got %b want 0", aft);
      end
   endtask

   task automatic test_stream();
      logic [7:0]  bytes [4];
      logic [63:0] p;
      logic [5:0]  l;
      logic [7:0]  b;
      int          n;
      bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      for (int pkt = 0; pkt < 4; pkt++) begin
         p = (pkt == 0) ? 64'h0000FFFF0000FFFF : {$urandom, $urandom};
         l = (pkt == 0) ? 6'd48 : 6'($urandom_range(0, 63));
         n = (pkt == 0) ? 4 : $urandom_range(1, 6);
         data_in_prefix = p; data_in_len = l; data_ready = 1'b1;
         tick();
         modelLearn(p, l);
         compared++;
         if ({pit_out_prefix, pit_out_len, prefix_ready} !== {p, l, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL offer got %h/%0d/%b want %h/%0d/1", pit_out_prefix, pit_out_len,
                     prefix_ready, p, l);
         end
         start_send_to_pit = 1'b1;
         tick();
         start_send_to_pit = 1'b0;
         compared++;
         if ({prefix_ready, out_data} !== {1'b1, 8'h00}) begin
            mismatched++;
            $display("[TB] FAIL accept got %b/%h want 1/00", prefix_ready, out_data);
         end
         for (int i = 0; i < n; i++) begin
            b = (pkt == 0) ? bytes[i] : 8'($urandom);
            data_in = b;
            tick();
            compared++;
            if (out_data !== b) begin
               mismatched++; $display("[TB] FAIL stream_byte got %h want %h", out_data, b);
            end
         end
         data_ready = 1'b0; data_in = '0;
         tick();
         compared++;
         if ({prefix_ready, out_data} !== 9'd0) begin
            mismatched++;
            $display("[TB] FAIL stream_end got %b/%h want 0/00", prefix_ready, out_data);
         end
      end
   endtask

   task automatic test_lpm();
      logic [63:0] req [3];
      logic [63:0] expP [3];
      logic [5:0]  expL [3];
      int lat; logic [63:0] gp; logic [5:0] gl; logic aft;
      req  = '{64'h0000FFFF0000FFFF, 64'h0000FFFF12340000, 64'h1234000000000000};
      expP = '{64'h0000FFFF00000000, 64'h0000FFFF00000000, 64'h0};
      expL = '{6'd48, 6'd32, 6'd0};
      doReset();
      learnPrefix(64'h0000FFFF00000000, 6'd32);
      learnPrefix(64'h0000FFFF0000FFFF, 6'd48);
      for (int i = 0; i < 3; i++) begin
         doLookup(req[i], 6'd63, lat, gp, gl, aft);
         compared++;
         if ({lat, gp, gl} !== {TB_DEPTH + 1, expP[i], expL[i]}) begin
            mismatched++;
            $display("[TB] FAIL lpm_%0d got %h/%0d lat %0d want %h/%0d lat %0d", i, gp, gl, lat,
                     expP[i], expL[i], TB_DEPTH + 1);
         end
      end
   endtask

   task automatic test_reject();
      logic [63:0] p, q;
      int lat; logic [63:0] gp; logic [5:0] gl; logic aft;
      p = 64'hABCD000000000000;
      q = {$urandom, $urandom};
      data_in_prefix = p; data_in_len = 6'd16; data_ready = 1'b1;
      tick();
      rejected = 1'b1; start_send_to_pit = 1'b1;
      tick();
      rejected = 1'b0; start_send_to_pit = 1'b0;
      compared++;
      if (prefix_ready !== 1'b0) begin
         mismatched++; $display("[TB] FAIL reject_drop got %b want 0", prefix_ready);
      end
      data_in = 8'h5A;
      tick(); tick();
      compared++;
      if ({prefix_ready, out_data} !== 9'd0) begin
         mismatched++;
         $display("[TB] FAIL reject_no_stream got %b/%h want 0/00", prefix_ready, out_data);
      end
      data_ready = 1'b0; data_in = '0;
      tick();
      modelLearn(p, 6'd16);
      data_in_prefix = q; data_in_len = 6'd40; data_ready = 1'b1;
      tick();
      compared++;
      if ({prefix_ready, pit_out_prefix} !== {1'b1, q}) begin
         mismatched++;
         $display("[TB] FAIL reoffer got %b/%h want 1/%h", prefix_ready, pit_out_prefix, q);
      end
      data_ready = 1'b0;
      tick();
      modelLearn(q, 6'd40);
      compared++;
      if (prefix_ready !== 1'b0) begin
         mismatched++; $display("[TB] FAIL offer_abort got %b want 0", prefix_ready);
      end
      doLookup(p | 64'h0000_1234_5678_9ABC, 6'd40, lat, gp, gl, aft);
      compared++;
      if ({gp, gl} !== {p, 6'd16}) begin
         mismatched++;
         $display("[TB] FAIL reject_learned got %h/%0d want %h/16", gp, gl, p);
      end
   endtask

   task automatic test_replace();
      logic [63:0] p [10];
      int lat; logic [63:0] gp, ep; logic [5:0] gl, el; logic aft;
      doReset();
      for (int i = 0; i < 10; i++) begin
         p[i] = {$urandom, $urandom};
         p[i][63:56] = (i == 9) ? 8'hF0 : 8'(i + 1);
      end
      for (int i = 0; i < 9; i++) learnPrefix(p[i], 6'd16);
      doLookup(p[0], 6'd63, lat, gp, gl, aft);
      compared++;
      if ({gp, gl} !== 70'd0) begin
         mismatched++; $display("[TB] FAIL evicted_first got %h/%0d want 0/0", gp, gl);
      end
      learnPrefix({p[1][63:48], 48'h0123456789AB}, 6'd16);
      learnPrefix(p[9], 6'd16);
      doLookup(p[1], 6'd63, lat, gp, gl, aft);
      compared++;
      if ({gp, gl} !== 70'd0) begin
         mismatched++; $display("[TB] FAIL evicted_second got %h/%0d want 0/0", gp, gl);
      end
      for (int i = 2; i < 10; i++) begin
         doLookup(p[i], 6'd63, lat, gp, gl, aft);
         modelLookup(p[i], 6'd63, ep, el);
         compared++;
         if ({gp, gl} !== {ep, el}) begin
            mismatched++;
            $display("[TB] FAIL replace_%0d got %h/%0d want %h/%0d", i, gp, gl, ep, el);
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] pool [4];
      logic [63:0] p, ep, gp;
      logic [5:0]  l, el, gl;
      int lat; logic aft;
      pool = '{64'h0000FFFF00000000, 64'h0A0B0C0D0E0F0000, 64'hFFFF000000000000, 64'h8000000000000001};
      doReset();
      for (int it = 0; it < 30; it++) begin
         p = pool[$urandom_range(0, 3)] ^ ({$urandom, $urandom} >> $urandom_range(8, 63));
         l = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            learnPrefix(p, l);
         end else begin
            doLookup(p, l, lat, gp, gl, aft);
            modelLookup(p, l, ep, el);
            compared++;
            if ({lat, gp, gl, aft} !== {TB_DEPTH + 1, ep, el, 1'b0}) begin
               mismatched++;
               $display("[TB] FAIL random_lookup got %h/%0d lat %0d want %h/%0d lat %0d",
                        gp, gl, lat, ep, el, TB_DEPTH + 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] p;
      int lat; logic [63:0] gp; logic [5:0] gl; logic aft; logic sawStrobe;
      p = 64'h0000FFFF0000FFFF;
      doReset();
      learnPrefix(64'h0000FFFF00000000, 6'd32);
      doLookup(p, 6'd63, lat, gp, gl, aft);
      compared++;
      if ({gp, gl} !== {64'h0000FFFF00000000, 6'd32}) begin
         mismatched++; $display("[TB] FAIL pre_reset_lookup got %h/%0d want 0000ffff00000000/32", gp, gl);
      end
      fib_out_bit = 1'b1;
      tick();
      fib_out_bit = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      compared++;
      if ({longest_matching_prefix, longest_matching_prefix_len, clk_out} !== 71'd0) begin
         mismatched++;
         $display("[TB] FAIL scan_reset got %h/%0d/%b want 0/0/0", longest_matching_prefix,
                  longest_matching_prefix_len, clk_out);
      end
      rst = 1'b1;
      modelClear();
      sawStrobe = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (clk_out !== 1'b0) sawStrobe = 1'b1;
      end
      compared++;
      if (sawStrobe !== 1'b0) begin
         mismatched++; $display("[TB] FAIL scan_abandoned got strobe want none");
      end
      data_in_prefix = p; data_in_len = 6'd48; data_ready = 1'b1;
      tick();
      start_send_to_pit = 1'b1;
      tick();
      start_send_to_pit = 1'b0; data_in = 8'h77;
      tick();
      compared++;
      if (out_data !== 8'h77) begin
         mismatched++; $display("[TB] FAIL pre_reset_stream got %h want 77", out_data);
      end
      rst = 1'b0; data_ready = 1'b0;
      tick();
      compared++;
      if ({pit_out_prefix, pit_out_len, prefix_ready, out_data} !== 79'd0) begin
         mismatched++;
         $display("[TB] FAIL stream_reset got %h/%0d/%b/%h want 0/0/0/00", pit_out_prefix,
                  pit_out_len, prefix_ready, out_data);
      end
      rst = 1'b1; data_in = '0;
      tick();
      doLookup(p, 6'd63, lat, gp, gl, aft);
      compared++;
      if ({lat, gp, gl} !== {TB_DEPTH + 1, 70'd0}) begin
         mismatched++;
         $display("[TB] FAIL post_reset_lookup got %h/%0d lat %0d want 0/0 lat %0d", gp, gl, lat,
                  TB_DEPTH + 1);
      end
   endtask

   // Scenario sequence, then the single summary line.
   initial begin
      test_reset();
      test_stream();
      test_lpm();
      test_reject();
      test_replace();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
